drive_mode_arbiter: RTL and testbench

Owns the chassis motion outputs and shares them between three requesters: manual panel, semi-auto driving and auto driving. A top-level mode request selects the requester. On every handover the arbiter drains the current owner, then forces a full-stop settle interval before granting the new owner. Sits between the driving-mode controllers and the motor/turn signal pins.

---
 rtl/drive_mode_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_drive_mode_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/drive_mode_arbiter.sv
// Chassis motion arbiter: hands the motor/turn outputs to one of manual, semi-auto or auto,
// draining the old owner and forcing a full-stop settle between owners. Optional: DRIVE_ARB_DRAIN_TIMEOUT_EN.
module drive_mode_arbiter #(
  parameter int SETTLE_CYCLES = 1_000_000,
  parameter int DRAIN_TIMEOUT = 50_000_000,
  parameter int CNT_W         = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       power_on,
  input  logic [1:0] mode_req,
  input  logic [3:0] man_cmd,
  input  logic [2:0] semi_cmd,
  input  logic       semi_busy,
  input  logic [2:0] auto_cmd,
  input  logic       auto_busy,
  input  logic       front_detector,
  output logic       move_forward_signal,
  output logic       move_backward_signal,
  output logic       turn_left_signal,
  output logic       turn_right_signal,
  output logic [2:0] grant,
  output logic [1:0] active_mode,
  output logic       switching
);

  typedef enum logic [2:0] {
    S_OFF,
    S_IDLE,
    S_ACTIVE,
    S_DRAIN,
    S_SETTLE
  } state_t;

  localparam logic [1:0]       MODE_NONE   = 2'b00;
  localparam logic [1:0]       MODE_MAN    = 2'b01;
  localparam logic [1:0]       MODE_SEMI   = 2'b10;
  localparam logic [1:0]       MODE_AUTO   = 2'b11;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state, state_d;
  logic [1:0]       owner, owner_d;
  logic [1:0]       target, target_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             owner_busy;
  logic             owned, owned_d;
  logic [3:0]       owner_motion;
  logic [3:0]       motion_p0;
  logic [3:0]       motion_p1;

`ifdef DRIVE_ARB_DRAIN_TIMEOUT_EN
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
  logic timeout_hit;
  logic drain_timeout_seen;
`else
  // Timeout disabled: the parameter stays for a uniform instantiation interface.
  logic [CNT_W-1:0] drain_last_unused;
  assign drain_last_unused = CNT_W'(DRAIN_TIMEOUT - 1);
`endif

  // Saturating increment: the interval counter parks at its terminal value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] last);
    return (v >= last) ? v : v + CNT_W'(1);
  endfunction

  // Manual panel {fwd, bwd, left, right}: opposing pairs cancel, obstacle blocks forward only.
  function automatic logic [3:0] map_manual(input logic [3:0] cmd, input logic front);
    logic fwd, bwd, lft, rgt;
    fwd = cmd[3] & ~cmd[2] & ~front;
    bwd = cmd[2] & ~cmd[3];
    lft = cmd[1] & ~cmd[0];
    rgt = cmd[0] & ~cmd[1];
    return {fwd, bwd, lft, rgt};
  endfunction

  // Semi/auto {fwd, left, right}: never reverses, and any multi-bit command is treated as stop.
  function automatic logic [3:0] map_steer(input logic [2:0] cmd);
    logic legal;
    legal = ~((cmd[2] & cmd[1]) | (cmd[2] & cmd[0]) | (cmd[1] & cmd[0]));
    return legal ? {cmd[2], 1'b0, cmd[1], cmd[0]} : 4'b0000;
  endfunction

  assign owner_busy = (owner == MODE_SEMI) ? semi_busy :
                      (owner == MODE_AUTO) ? auto_busy : 1'b0;

  always_comb begin
    state_d  = state;
    owner_d  = owner;
    target_d = target;
    cnt_d    = cnt;
`ifdef DRIVE_ARB_DRAIN_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      S_OFF: begin
        owner_d  = MODE_NONE;
        target_d = MODE_NONE;
        cnt_d    = '0;
        if (power_on) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (mode_req != MODE_NONE) begin
          state_d  = S_SETTLE;
          target_d = mode_req;
          cnt_d    = '0;
        end
      end
      S_ACTIVE: begin
        if (mode_req != owner) begin
          cnt_d = '0;
          if (owner_busy) begin
            state_d = S_DRAIN;
          end else begin
            state_d  = S_SETTLE;
            target_d = mode_req;
            owner_d  = MODE_NONE;
          end
        end
      end
      S_DRAIN: begin
        if (mode_req == owner) begin
          state_d = S_ACTIVE;
        end else if (!owner_busy) begin
          state_d  = S_SETTLE;
          target_d = mode_req;
          owner_d  = MODE_NONE;
          cnt_d    = '0;
`ifdef DRIVE_ARB_DRAIN_TIMEOUT_EN
        end else if (cnt == DRAIN_LAST) begin
          state_d     = S_SETTLE;
          target_d    = mode_req;
          owner_d     = MODE_NONE;
          cnt_d       = '0;
          timeout_hit = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt, DRAIN_LAST);
`endif
        end
      end
      S_SETTLE: begin
        // A new request during settle restarts the full-stop interval.
        if (mode_req != target) begin
          target_d = mode_req;
          cnt_d    = '0;
        end else if (cnt == SETTLE_LAST) begin
          if (target == MODE_NONE) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_ACTIVE;
            owner_d = target;
          end
        end else begin
          cnt_d = sat_inc(cnt, SETTLE_LAST);
        end
      end
      default: state_d = S_OFF;
    endcase

    if (!power_on) begin
      state_d  = S_OFF;
      owner_d  = MODE_NONE;
      target_d = MODE_NONE;
      cnt_d    = '0;
`ifdef DRIVE_ARB_DRAIN_TIMEOUT_EN
      timeout_hit = 1'b0;
`endif
    end
  end

  always_comb begin
    owner_motion = 4'b0000;
    case (owner)
      MODE_MAN:  owner_motion = map_manual(man_cmd, front_detector);
      MODE_SEMI: owner_motion = map_steer(semi_cmd);
      MODE_AUTO: owner_motion = map_steer(auto_cmd);
      default:   owner_motion = 4'b0000;
    endcase
  end

  // Stage p0: pass the owner's command only while it stays owned across this edge.
  assign owned     = (state == S_ACTIVE) || (state == S_DRAIN);
  assign owned_d   = (state_d == S_ACTIVE) || (state_d == S_DRAIN);
  assign motion_p0 = (owned && owned_d) ? owner_motion : 4'b0000;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_OFF;
      owner     <= MODE_NONE;
      target    <= MODE_NONE;
      cnt       <= '0;
      motion_p1 <= 4'b0000;
    end else begin
      state     <= state_d;
      owner     <= owner_d;
      target    <= target_d;
      cnt       <= cnt_d;
      motion_p1 <= motion_p0;
    end
  end

`ifdef DRIVE_ARB_DRAIN_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drain_timeout_seen <= 1'b0;
    end else if (timeout_hit) begin
      drain_timeout_seen <= 1'b1;
    end
  end
`endif

  // Stage p1: registered motion pins; ownership outputs decode straight from state.
  assign move_forward_signal  = motion_p1[3];
  assign move_backward_signal = motion_p1[2];
  assign turn_left_signal     = motion_p1[1];
  assign turn_right_signal    = motion_p1[0];

  assign grant       = owned ? {owner == MODE_AUTO, owner == MODE_SEMI, owner == MODE_MAN} : 3'b000;
  assign active_mode = owned ? owner : MODE_NONE;
  assign switching   = (state == S_DRAIN) || (state == S_SETTLE);

endmodule

// File: tb/tb_drive_mode_arbiter.sv
// Directed bench for drive_mode_arbiter with a short settle (4) and drain timeout (8).
module tb_drive_mode_arbiter;

  logic       clk;
  logic       rst;
  logic       power_on;
  logic [1:0] mode_req;
  logic [3:0] man_cmd;
  logic [2:0] semi_cmd;
  logic       semi_busy;
  logic [2:0] auto_cmd;
  logic       auto_busy;
  logic       front_detector;
  logic       move_forward_signal;
  logic       move_backward_signal;
  logic       turn_left_signal;
  logic       turn_right_signal;
  logic [2:0] grant;
  logic [1:0] active_mode;
  logic       switching;

  logic [7:0] motion8, grant8, mode8, sw8;
  int         n_checks;
  int         n_errors;

  drive_mode_arbiter #(
    .SETTLE_CYCLES(4),
    .DRAIN_TIMEOUT(8),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .power_on(power_on),
    .mode_req(mode_req),
    .man_cmd(man_cmd),
    .semi_cmd(semi_cmd),
    .semi_busy(semi_busy),
    .auto_cmd(auto_cmd),
    .auto_busy(auto_busy),
    .front_detector(front_detector),
    .move_forward_signal(move_forward_signal),
    .move_backward_signal(move_backward_signal),
    .turn_left_signal(turn_left_signal),
    .turn_right_signal(turn_right_signal),
    .grant(grant),
    .active_mode(active_mode),
    .switching(switching)
  );

  assign motion8 = {4'b0, move_forward_signal, move_backward_signal, turn_left_signal, turn_right_signal};
  assign grant8  = {5'b0, grant};
  assign mode8   = {6'b0, active_mode};
  assign sw8     = {7'b0, switching};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%02h exp=%02h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; power_on = 1'b0; mode_req = 2'b00; man_cmd = 4'b0000;
    semi_cmd = 3'b000; semi_busy = 1'b0; auto_cmd = 3'b000; auto_busy = 1'b0;
    front_detector = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rst_grant", grant8, 8'h00);
    check("rst_motion", motion8, 8'h00);
    check("rst_mode", mode8, 8'h00);
    check("rst_switching", sw8, 8'h00);
    tick(); tick();
    rst = 1'b1;

    // Power up into manual: IDLE, 4 settle cycles, then ACTIVE with one-cycle output latency
    power_on = 1'b1; mode_req = 2'b01; man_cmd = 4'b1000;
    tick();
    check("idle_grant", grant8, 8'h00);
    check("idle_switching", sw8, 8'h00);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("settle1_grant", grant8, 8'h00);
      check("settle1_motion", motion8, 8'h00);
      check("settle1_switching", sw8, 8'h01);
      tick();
    end
    check("act1_grant", grant8, 8'h01);
    check("act1_mode", mode8, 8'h01);
    check("act1_first_motion", motion8, 8'h00);
    tick();
    check("act1_forward", motion8, 8'h08);

    // Manual mapping
    man_cmd = 4'b1100; tick();
    check("man_fwd_bwd_cancel", motion8, 8'h00);
    man_cmd = 4'b1000; front_detector = 1'b1; tick();
    check("man_fwd_masked", motion8, 8'h00);
    man_cmd = 4'b0100; tick();
    check("man_bwd_unmasked", motion8, 8'h04);
    man_cmd = 4'b0011; front_detector = 1'b0; tick();
    check("man_lr_cancel", motion8, 8'h00);
    man_cmd = 4'b0010; tick();
    check("man_left", motion8, 8'h02);

    // Manual -> semi: no drain for manual
    mode_req = 2'b10; semi_cmd = 3'b010; semi_busy = 1'b1;
    tick();
    check("m2s_switching", sw8, 8'h01);
    check("m2s_grant", grant8, 8'h00);
    check("m2s_motion", motion8, 8'h00);
    repeat (3) tick();
    check("m2s_settle_end_grant", grant8, 8'h00);
    tick();
    check("semi_grant", grant8, 8'h02);
    tick();
    check("semi_left", motion8, 8'h02);

    // Semi busy -> drain keeps the turn going, then settle, then auto
    mode_req = 2'b11; auto_cmd = 3'b100;
    tick();
    check("drain_switching", sw8, 8'h01);
    check("drain_grant", grant8, 8'h02);
    check("drain_motion", motion8, 8'h02);
    tick();
    check("drain_hold_motion", motion8, 8'h02);
    semi_busy = 1'b0;
    tick();
    check("s2a_settle_motion", motion8, 8'h00);
    check("s2a_settle_grant", grant8, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("s2a_settle_grant_n", grant8, 8'h00);
      check("s2a_settle_motion_n", motion8, 8'h00);
    end
    tick();
    check("auto_grant", grant8, 8'h04);
    check("auto_mode", mode8, 8'h03);
    tick();
    check("auto_forward", motion8, 8'h08);

    // Drain cancelled by returning to the owner
    auto_busy = 1'b1; mode_req = 2'b10;
    tick();
    check("ret_drain_switching", sw8, 8'h01);
    mode_req = 2'b11;
    tick();
    check("ret_active_switching", sw8, 8'h00);
    check("ret_active_grant", grant8, 8'h04);
    check("ret_active_motion", motion8, 8'h08);
    auto_cmd = 3'b110; tick();
    check("auto_illegal", motion8, 8'h00);
    auto_cmd = 3'b001; tick();
    check("auto_right", motion8, 8'h01);

    // Settle restarts on every request change
    auto_busy = 1'b0; mode_req = 2'b01;
    tick(); tick(); tick();
    mode_req = 2'b10;
    tick(); tick();
    check("restart1_no_early_grant", grant8, 8'h00);
    mode_req = 2'b11;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("restart2_grant", grant8, 8'h00);
    end
    tick();
    check("restart_final_grant", grant8, 8'h04);
    tick();
    check("restart_final_motion", motion8, 8'h01);

    // Asynchronous reset mid-ACTIVE and mid-SETTLE
    #2 rst = 1'b0;
    #1;
    check("arst_active_grant", grant8, 8'h00);
    check("arst_active_motion", motion8, 8'h00);
    check("arst_active_mode", mode8, 8'h00);
    rst = 1'b1;
    tick(); tick(); tick();
    check("pre_arst_settle_switching", sw8, 8'h01);
    #2 rst = 1'b0;
    #1;
    check("arst_settle_switching", sw8, 8'h00);
    check("arst_settle_grant", grant8, 8'h00);
    rst = 1'b1;
    tick(); tick();
    repeat (4) tick();
    check("reup_grant", grant8, 8'h04);
    tick();
    check("reup_motion", motion8, 8'h01);

    // Power off from ACTIVE
    power_on = 1'b0;
    tick();
    check("off_grant", grant8, 8'h00);
    check("off_motion", motion8, 8'h00);
    check("off_mode", mode8, 8'h00);
    power_on = 1'b1;
    tick(); tick();
    repeat (4) tick();
    check("reup2_grant", grant8, 8'h04);

    // Auto stuck busy in DRAIN
    auto_busy = 1'b1; mode_req = 2'b01;
    tick();
    check("to_drain_switching", sw8, 8'h01);
    repeat (7) tick();
    check("to_drain_pre_grant", grant8, 8'h04);
    tick();
`ifdef DRIVE_ARB_DRAIN_TIMEOUT_EN
    check("to_forced_settle_grant", grant8, 8'h00);
    check("to_forced_settle_switching", sw8, 8'h01);
    check("to_seen_flag", {7'b0, dut.drain_timeout_seen}, 8'h01);
`else
    check("to_still_drain_grant", grant8, 8'h04);
    check("to_still_drain_switching", sw8, 8'h01);
    repeat (20) tick();
    check("to_still_drain_late", grant8, 8'h04);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
